// File: rtl/mcpu_soc_video_capture_pkg.sv
// Shared constants and helpers for the video capture block: pixel, block and
// burst geometry, the writer state type and small arithmetic helpers.
package mcpu_soc_video_capture_pkg;

  localparam int BEAT_CNT   = 8;
  localparam int PIX_W      = 24;
  localparam int BLK_W      = 1024;
  localparam int BEAT_W     = BLK_W / BEAT_CNT;
  localparam int ACC_W      = BLK_W + PIX_W;
  localparam int FILL_W     = 11;
  localparam int BEAT_IDX_W = 3;
  localparam int ADDR_W     = 22;

  localparam logic [FILL_W-1:0]     FILL_BLK  = FILL_W'(BLK_W);
  localparam logic [FILL_W-1:0]     FILL_PIX  = FILL_W'(PIX_W);
  localparam logic [BEAT_IDX_W-1:0] BEAT_LAST = BEAT_IDX_W'(BEAT_CNT - 1);

  typedef enum logic [0:0] {
    WR_IDLE  = 1'b0,
    WR_BURST = 1'b1
  } wr_state_e;

  // Pixel word as it lands in the frame bitstream: red in the low byte.
  function automatic logic [PIX_W-1:0] pack_pixel(input logic [7:0] r,
                                                  input logic [7:0] g,
                                                  input logic [7:0] b);
    return {b, g, r};
  endfunction

  // Block offset within the frame, wrapping after the last block.
  function automatic logic [ADDR_W-1:0] next_offset(input logic [ADDR_W-1:0] ofs,
                                                    input logic [ADDR_W-1:0] last);
    return (ofs == last) ? '0 : ofs + 1'b1;
  endfunction

endpackage

// File: rtl/mcpu_soc_video_capture_fifo.sv
// Generic synchronous FIFO with first-word-fall-through read data.
// The caller must not push when full unless it pops in the same cycle.
module mcpu_soc_video_capture_fifo #(
  parameter int WIDTH = 1024,
  parameter int DEPTH = 4
) (
  input  logic             clkrst_core_clk,
  input  logic             clkrst_core_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // Storage array; data only, never reset.
  always_ff @(posedge clkrst_core_clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mcpu_soc_video_capture.sv
// Video capture to memory: packs 24-bit pixels LSB-first into 1024-bit
// blocks, queues them, and writes each block as an 8-beat 128-bit burst.
module mcpu_soc_video_capture
  import mcpu_soc_video_capture_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 22'h200,
  parameter int                NUM_BLOCKS = 7200,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              clkrst_core_clk,
  input  logic              clkrst_core_rst,
  input  logic              cap_valid,
  input  logic              cap_vsync,
  input  logic              cap_de,
  input  logic [7:0]        cap_r,
  input  logic [7:0]        cap_g,
  input  logic [7:0]        cap_b,
  input  logic              cap_clr,
  output logic              video2ltc_we,
  output logic [ADDR_W-1:0] video2ltc_addr,
  output logic [BEAT_W-1:0] video2ltc_wdata,
  output logic              video2ltc_wlast,
  input  logic              video2ltc_stall,
  output logic              cap_overflow,
  output logic              cap_short_frame
);

  localparam logic [ADDR_W-1:0] OFS_LAST = ADDR_W'(NUM_BLOCKS - 1);

  logic [ACC_W-1:0]  acc_p0, acc_d, acc_base;
  logic [FILL_W-1:0] fill_p0, fill_d, fill_base;
  logic [ADDR_W-1:0] ofs_p0, ofs_d, push_addr;
  logic              vsync_p0, ovf_p0, short_p0;
  logic              vs_edge, pix_ok, blk_rdy, drop, short_set;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic              blk_full, blk_empty, adr_full, adr_empty;
  logic [BLK_W-1:0]  blk_head;
  logic [ADDR_W-1:0] adr_head;

  wr_state_e         state_p1, state_d;
  logic [BEAT_IDX_W-1:0] beat_p1;
  logic [BLK_W-1:0]  sreg_p1;
  logic [ADDR_W-1:0] baddr_p1;
  logic              load, shift;

  // ---- stage p0: pixel accumulation and block completion ----
  assign vs_edge   = cap_vsync & ~vsync_p0;
  assign pix_ok    = cap_valid & cap_de;
  assign blk_rdy   = (fill_p0 >= FILL_BLK);
  assign push_addr = BASE_ADDR + ofs_p0;
  assign fifo_push = blk_rdy & (~fifo_full | fifo_pop);
  assign drop      = blk_rdy & fifo_full & ~fifo_pop;

  // Next accumulator/fill/offset: retire a completed block, then apply a
  // vsync restart, then append the current pixel (so it becomes pixel 0).
  always_comb begin
    acc_base  = acc_p0;
    fill_base = fill_p0;
    ofs_d     = ofs_p0;
    if (blk_rdy) begin
      acc_base  = acc_p0 >> BLK_W;
      fill_base = fill_p0 - FILL_BLK;
      ofs_d     = next_offset(ofs_p0, OFS_LAST);
    end
    short_set = vs_edge & (fill_base != '0);
    if (vs_edge) begin
      acc_base  = '0;
      fill_base = '0;
      ofs_d     = '0;
    end
    acc_d  = acc_base;
    fill_d = fill_base;
    if (pix_ok) begin
      acc_d  = acc_base | (ACC_W'(pack_pixel(cap_r, cap_g, cap_b)) << fill_base);
      fill_d = fill_base + FILL_PIX;
    end
  end

  // Accumulator, fill count, block offset and vsync history.
  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst) begin
      acc_p0   <= '0;
      fill_p0  <= '0;
      ofs_p0   <= '0;
      vsync_p0 <= 1'b0;
    end else begin
      acc_p0   <= acc_d;
      fill_p0  <= fill_d;
      ofs_p0   <= ofs_d;
      vsync_p0 <= cap_vsync;
    end
  end

  // Sticky status; a set event in the same cycle as a clear wins.
  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst) begin
      ovf_p0   <= 1'b0;
      short_p0 <= 1'b0;
    end else begin
      if (drop)         ovf_p0 <= 1'b1;
      else if (cap_clr) ovf_p0 <= 1'b0;
      if (short_set)    short_p0 <= 1'b1;
      else if (cap_clr) short_p0 <= 1'b0;
    end
  end

  assign cap_overflow    = ovf_p0;
  assign cap_short_frame = short_p0;

  // Block data and its address travel in lock-step queues.
  mcpu_soc_video_capture_fifo #(
    .WIDTH (BLK_W),
    .DEPTH (FIFO_DEPTH)
  ) u_blk_fifo (
    .clkrst_core_clk (clkrst_core_clk),
    .clkrst_core_rst (clkrst_core_rst),
    .push            (fifo_push),
    .push_data       (acc_p0[BLK_W-1:0]),
    .pop             (fifo_pop),
    .pop_data        (blk_head),
    .full            (blk_full),
    .empty           (blk_empty)
  );

  mcpu_soc_video_capture_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_adr_fifo (
    .clkrst_core_clk (clkrst_core_clk),
    .clkrst_core_rst (clkrst_core_rst),
    .push            (fifo_push),
    .push_data       (push_addr),
    .pop             (fifo_pop),
    .pop_data        (adr_head),
    .full            (adr_full),
    .empty           (adr_empty)
  );

  assign fifo_full  = blk_full | adr_full;
  assign fifo_empty = blk_empty | adr_empty;

  // ---- stage p1: burst writer ----
  // Writer next state: pop on entry to a burst and directly after beat 7
  // when another block is waiting, so back-to-back bursts have no gap.
  always_comb begin
    state_d  = state_p1;
    fifo_pop = 1'b0;
    load     = 1'b0;
    shift    = 1'b0;
    case (state_p1)
      WR_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          load     = 1'b1;
          state_d  = WR_BURST;
        end
      end
      WR_BURST: begin
        if (!video2ltc_stall) begin
          if (beat_p1 == BEAT_LAST) begin
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              load     = 1'b1;
            end else begin
              state_d = WR_IDLE;
            end
          end else begin
            shift = 1'b1;
          end
        end
      end
      default: state_d = WR_IDLE;
    endcase
  end

  // Writer state register.
  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst) state_p1 <= WR_IDLE;
    else                 state_p1 <= state_d;
  end

  // Burst shift register, address and beat counter; all hold while stalled.
  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst) begin
      sreg_p1  <= '0;
      baddr_p1 <= '0;
      beat_p1  <= '0;
    end else if (load) begin
      sreg_p1  <= blk_head;
      baddr_p1 <= adr_head;
      beat_p1  <= '0;
    end else if (shift) begin
      sreg_p1  <= sreg_p1 >> BEAT_W;
      beat_p1  <= beat_p1 + 1'b1;
    end
  end

  assign video2ltc_we    = (state_p1 == WR_BURST);
  assign video2ltc_wlast = (state_p1 == WR_BURST) && (beat_p1 == BEAT_LAST);
  assign video2ltc_addr  = baddr_p1;
  assign video2ltc_wdata = sreg_p1[BEAT_W-1:0];

endmodule

// File: tb/tb_mcpu_soc_video_capture.sv
// Testbench for mcpu_soc_video_capture: bitstream reference model feeding a
// scoreboard of expected write beats, with a separate beat monitor.
module tb_mcpu_soc_video_capture;

  localparam int          NB   = 9;
  localparam logic [21:0] BASE = 22'h200;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cap_valid = 1'b0, cap_vsync = 1'b0, cap_de = 1'b0, cap_clr = 1'b0;
  logic [7:0]   cap_r = '0, cap_g = '0, cap_b = '0;
  logic         stall = 1'b0;
  logic         we, wlast, ovf, shrt;
  logic [21:0]  addr;
  logic [127:0] wdata;

  always #5 clk = ~clk;

  mcpu_soc_video_capture #(
    .BASE_ADDR  (BASE),
    .NUM_BLOCKS (NB),
    .FIFO_DEPTH (4)
  ) dut (
    .clkrst_core_clk (clk),
    .clkrst_core_rst (rst),
    .cap_valid       (cap_valid),
    .cap_vsync       (cap_vsync),
    .cap_de          (cap_de),
    .cap_r           (cap_r),
    .cap_g           (cap_g),
    .cap_b           (cap_b),
    .cap_clr         (cap_clr),
    .video2ltc_we    (we),
    .video2ltc_addr  (addr),
    .video2ltc_wdata (wdata),
    .video2ltc_wlast (wlast),
    .video2ltc_stall (stall),
    .cap_overflow    (ovf),
    .cap_short_frame (shrt)
  );

  typedef struct {
    logic [21:0]  addr;
    logic [127:0] data;
    logic         last;
  } beat_t;

  beat_t exp_q[$];
  bit    bits_q[$];
  int    m_ofs = 0;
  bit    m_vs_prev = 0, m_short = 0, m_ovf = 0;
  int    blk_cnt = 0;
  int    drop_idx = -1;
  int    n_cmp = 0, n_fail = 0;
  int    beats_acc = 0;
  logic [127:0] last_beat = '0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: the frame is a plain bit queue; every 1024 bits form a
  // block written as 8 beats at BASE + block index (mod NB) within the frame.
  task automatic model_cycle(input bit vs, input bit pix_on, input logic [23:0] pix, input bit clr);
    logic [1023:0] blk;
    beat_t         e;
    if (clr) begin m_short = 0; m_ovf = 0; end
    if (vs && !m_vs_prev) begin
      if (bits_q.size() != 0) m_short = 1;
      bits_q.delete();
      m_ofs = 0;
    end
    m_vs_prev = vs;
    if (pix_on) begin
      for (int i = 0; i < 24; i++) bits_q.push_back(pix[i]);
      if (bits_q.size() >= 1024) begin
        for (int i = 0; i < 1024; i++) blk[i] = bits_q.pop_front();
        if (blk_cnt == drop_idx) m_ovf = 1;
        else begin
          for (int b = 0; b < 8; b++) begin
            e.addr = BASE + 22'(m_ofs);
            e.data = blk[128*b +: 128];
            e.last = (b == 7);
            exp_q.push_back(e);
          end
        end
        blk_cnt++;
        m_ofs = (m_ofs + 1) % NB;
      end
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    bits_q.delete();
    m_ofs = 0; m_vs_prev = 0; m_short = 0; m_ovf = 0;
  endtask

  // One clock of stimulus, entered and left at posedge + 1.
  task automatic step(input bit vs, input bit v, input bit de, input logic [7:0] r,
                      input logic [7:0] g, input logic [7:0] b, input bit st, input bit clr);
    cap_vsync = vs; cap_valid = v; cap_de = de;
    cap_r = r; cap_g = g; cap_b = b;
    stall = st; cap_clr = clr;
    model_cycle(vs, v && de, {b, g, r}, clr);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input bit st);
    for (int i = 0; i < n; i++) step(0, 0, 0, 8'h0, 8'h0, 8'h0, st, 0);
  endtask

  task automatic drain(input string nm, input bit rnd_stall);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 400) begin
      step(0, 0, 0, 8'h0, 8'h0, 8'h0, rnd_stall ? ($urandom_range(3) == 0) : 1'b0, 0);
      guard++;
    end
    check({nm, "_drain_left"}, 128'(exp_q.size()), 128'd0);
    idle(12, 0);
  endtask

  task automatic ramp_pixels(input int n);
    for (int k = 0; k < n; k++) step(0, 1, 1, 8'(k), 8'(k + 1), 8'(k + 2), 0, 0);
  endtask

  // Beat monitor: every accepted beat pops one expectation; a stalled beat
  // must reappear unchanged on the next cycle.
  bit           h_v = 0;
  logic [21:0]  h_addr;
  logic [127:0] h_data;
  logic         h_last;
  beat_t        m_e;
  always @(negedge clk) begin
    if (rst) h_v = 0;
    else begin
      if (h_v) begin
        check("hold_we", 128'(we), 128'd1);
        check("hold_addr", 128'(addr), 128'(h_addr));
        check("hold_wdata", wdata, h_data);
        check("hold_wlast", 128'(wlast), 128'(h_last));
      end
      h_v = 0;
      if (we && stall) begin
        h_v = 1; h_addr = addr; h_data = wdata; h_last = wlast;
      end else if (we && !stall) begin
        if (exp_q.size() == 0) check("unexpected_beat", 128'(addr), 128'h3fffff);
        else begin
          m_e = exp_q.pop_front();
          check("beat_addr", 128'(addr), 128'(m_e.addr));
          check("beat_wdata", wdata, m_e.data);
          check("beat_wlast", 128'(wlast), 128'(m_e.last));
        end
        last_beat = wdata;
        beats_acc++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int start, guard, t0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_we", 128'(we), 128'd0);
    check("rst_wlast", 128'(wlast), 128'd0);
    check("rst_addr", 128'(addr), 128'd0);
    check("rst_wdata", wdata, 128'd0);
    check("rst_ovf", 128'(ovf), 128'd0);
    check("rst_short", 128'(shrt), 128'd0);
    rst = 1'b0;
    model_reset();

    // Ramp pixels 0..42, then first-beat latency from the completing pixel
    for (int k = 0; k < 42; k++) step(0, 1, 1, 8'(k), 8'(k + 1), 8'(k + 2), 0, 0);
    step(0, 1, 1, 8'd42, 8'd43, 8'd44, 0, 0);
    t0 = 0;
    while (!we && t0 < 10) begin @(negedge clk); if (!we) begin @(posedge clk); #1; t0++; end end
    check("latency_T3", 128'(t0), 128'd2);
    drain("ramp", 0);
    check("ramp_beat7_hi", 128'(last_beat[127:112]), 128'h2b2a);

    // Vsync with 8 bits pending, with a clear in the same cycle
    step(1, 0, 0, 8'h0, 8'h0, 8'h0, 0, 1);
    idle(2, 0);
    check("short_after_ramp", 128'(shrt), 128'(m_short));
    check("short_set_wins", 128'(shrt), 128'd1);
    step(0, 0, 0, 8'h0, 8'h0, 8'h0, 0, 1);
    idle(1, 0);
    check("short_cleared", 128'(shrt), 128'd0);

    // Short frame of 10 pixels, then a full block in the next frame
    ramp_pixels(10);
    step(1, 0, 0, 8'h0, 8'h0, 8'h0, 0, 0);
    step(0, 0, 0, 8'h0, 8'h0, 8'h0, 0, 0);
    idle(2, 0);
    check("short_10px", 128'(shrt), 128'(m_short));
    check("short_10px_beats", 128'(exp_q.size()), 128'd0);
    ramp_pixels(43);
    drain("after_short", 0);

    // Permanent stall: 6 blocks, the 6th is dropped, offset keeps counting
    step(1, 0, 0, 8'h0, 8'h0, 8'h0, 0, 1);
    step(0, 0, 0, 8'h0, 8'h0, 8'h0, 0, 1);
    drop_idx = blk_cnt + 5;
    for (int k = 0; k < 256; k++) step(0, 1, 1, 8'($urandom), 8'($urandom), 8'($urandom), 1, 0);
    idle(4, 1);
    check("ovf_set", 128'(ovf), 128'(m_ovf));
    check("ovf_queued_beats", 128'(exp_q.size()), 128'd40);
    drop_idx = -1;
    drain("ovf", 0);
    for (int k = 0; k < 43; k++) step(0, 1, 1, 8'($urandom), 8'($urandom), 8'($urandom), 0, 0);
    check("ovf_next_addr", 128'(exp_q[0].addr), 128'(BASE + 22'd6));
    drain("ovf_next", 0);
    step(0, 0, 0, 8'h0, 8'h0, 8'h0, 0, 1);
    idle(1, 0);
    check("ovf_cleared", 128'(ovf), 128'd0);

    // Randomised frames with random stall, blanking and vsync pulses
    for (int f = 0; f < 3; f++) begin
      step(1, 1, 1, 8'($urandom), 8'($urandom), 8'($urandom), 0, 0);
      step(1, $urandom_range(1), 1, 8'($urandom), 8'($urandom), 8'($urandom), 0, 0);
      for (int c = 0; c < 600; c++)
        step(0, $urandom_range(3) != 0, $urandom_range(7) != 0, 8'($urandom), 8'($urandom),
             8'($urandom), $urandom_range(3) == 0, 0);
      drain("random", 1);
      check("random_ovf", 128'(ovf), 128'(m_ovf));
      check("random_short", 128'(shrt), 128'(m_short));
    end

    // Reset in the middle of a burst (beat 4 presented)
    step(1, 0, 0, 8'h0, 8'h0, 8'h0, 0, 1);
    step(0, 0, 0, 8'h0, 8'h0, 8'h0, 0, 0);
    start = beats_acc;
    ramp_pixels(43);
    guard = 0;
    while (beats_acc < start + 4 && guard < 50) begin idle(1, 0); guard++; end
    check("rst_mid_reach_beat4", 128'(beats_acc - start), 128'd4);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_we", 128'(we), 128'd0);
    check("rst_mid_wlast", 128'(wlast), 128'd0);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 43; k++) step(0, 1, 1, 8'(k + 7), 8'(k * 3), 8'(255 - k), 0, 0);
    check("rst_mid_new_addr", 128'(exp_q[0].addr), 128'(BASE));
    drain("after_rst", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
